// File: rtl/mdu_if.sv
// mdu_if: handshake/result bundle between EX-stage control and the multiply/divide unit
//   start : op valid this cycle
//   op    : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a, b  : rs / rt operands
//   pc    : PC of the EX instruction, used only for the commit trace
//   busy  : operation in flight
//   hi, lo: architectural HI/LO
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, op, a, b, pc, input busy, hi, lo);
    modport slave  (input start, op, a, b, pc, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit holding the HI/LO registers
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears busy, hi, lo and any pending result
//   bus   : mdu_if.slave (start/op/a/b/pc in, busy/hi/lo out)
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [31:0]   pc_q, pc_d;
    logic          accept, is_mul, is_div, sgn, na, nb, done, upd;
    logic [63:0]   ea, eb, prod;
    logic [31:0]   ma, mb, uq, ur, q, r, trace_pc;
    always_comb begin
        accept = bus.start && state_q == IDLE;
        is_mul = bus.op[2:1] == 2'd0;
        is_div = bus.op[2:1] == 2'd1;
        sgn = !bus.op[0];
        // Low 64 bits of the product of extended operands give both signed and unsigned results
        ea = {{32{sgn & bus.a[31]}}, bus.a};
        eb = {{32{sgn & bus.b[31]}}, bus.b};
        prod = ea * eb;
        // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
        na = sgn & bus.a[31];
        nb = sgn & bus.b[31];
        ma = na ? -bus.a : bus.a;
        mb = nb ? -bus.b : bus.b;
        uq = ma / mb;
        ur = ma % mb;
        q = (na ^ nb) ? -uq : uq;
        r = na ? -ur : ur;
        done = state_q == RUN && cnt_q == CW'(1);
        state_d = state_q;
        cnt_d = state_q == RUN ? cnt_q - 1'b1 : cnt_q;
        hi_d = hi_q;
        lo_d = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pc_d = pc_q;
        if (accept && (is_mul || is_div)) begin
            state_d = RUN;
            cnt_d = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            pend_hi_d = is_mul ? prod[63:32] : (bus.b == '0 ? bus.a : r);
            pend_lo_d = is_mul ? prod[31:0] : (bus.b == '0 ? '1 : q);
            pc_d = bus.pc;
        end
        if (accept && bus.op == 3'd4) hi_d = bus.a;
        if (accept && bus.op == 3'd5) lo_d = bus.a;
        if (done) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
            state_d = IDLE;
        end
        upd = done || (accept && (bus.op == 3'd4 || bus.op == 3'd5));
        trace_pc = done ? pc_q : bus.pc;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pc_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pc_q <= pc_d;
        end
    end
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && upd) $display("%0t mdu commit pc=%h hi=%h lo=%h", $time, trace_pc, hi_d, lo_d);
    end
`endif
    assign bus.busy = state_q == RUN;
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed and random stimulus for mdu checked against an arithmetic reference model
module tb_mdu;
    localparam int MULT_N = 5;
    localparam int DIV_N = 10;
    logic clk;
    logic reset;
    mdu_if bus ();
    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (.clk(clk), .reset(reset), .bus(bus));
    int passed = 0;
    int total = 0;
    int fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] pc_ctr = 32'h0040_0000;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, qq, mm;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: return sx * sy;
            3'd1: return {32'b0, x} * {32'b0, y};
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                qq = sx / sy;
                mm = sx % sy;
                return {mm[31:0], qq[31:0]};
            end
            3'd3: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: return 64'd0;
        endcase
    endfunction
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] res;
        int n;
        res = ref_op(o, x, y);
        n = (o < 2) ? MULT_N : (o < 4) ? DIV_N : 0;
        bus.start = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        bus.pc = pc_ctr;
        pc_ctr += 4;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("busy_run", {31'b0, bus.busy}, 32'd1);
            chk("hi_hold", bus.hi, m_hi);
            chk("lo_hold", bus.lo, m_lo);
            tick();
        end
        if (n > 0) {m_hi, m_lo} = res;
        else if (o == 3'd4) m_hi = x;
        else if (o == 3'd5) m_lo = x;
        chk("busy_done", {31'b0, bus.busy}, 32'd0);
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
    endtask
    initial begin
        logic [2:0] o;
        logic [31:0] x, y;
        logic [63:0] res;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.pc = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        chk("t1_hi", bus.hi, 32'hFFFF_FFFF);
        chk("t1_lo", bus.lo, 32'hFFFF_FFEB);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t2_hi", bus.hi, 32'hFFFF_FFFE);
        chk("t2_lo", bus.lo, 32'h0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("t3_hi", bus.hi, 32'hFFFF_FFFF);
        chk("t3_lo", bus.lo, 32'hFFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd0);
        chk("t3z_hi", bus.hi, 32'd7);
        chk("t3z_lo", bus.lo, 32'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("t4_hi", bus.hi, 32'd0);
        chk("t4_lo", bus.lo, 32'h8000_0000);
        run_op(3'd4, 32'h1234, 32'hDEAD_BEEF);
        chk("mthi_hi", bus.hi, 32'h1234);
        chk("mthi_lo", bus.lo, 32'h8000_0000);
        run_op(3'd5, 32'h5678, 32'd0);
        chk("mtlo_lo", bus.lo, 32'h5678);
        chk("mtlo_hi", bus.hi, 32'h1234);
        run_op(3'd6, 32'hAAAA_AAAA, 32'd3);
        run_op(3'd7, 32'h5555_5555, 32'd3);
        run_op(3'd2, 32'd0, 32'd0);
        for (int k = 0; k < 40; k++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 5) == 0) y = '0;
            if ($urandom_range(0, 9) == 0) begin
                x = 32'h8000_0000;
                y = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
            run_op(o, x, y);
        end
        // MULT in flight; MTLO arriving in its second busy cycle must be dropped
        x = $urandom;
        y = $urandom;
        res = ref_op(3'd0, x, y);
        bus.start = 1'b1;
        bus.op = 3'd0;
        bus.a = x;
        bus.b = y;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < MULT_N; i++) begin
            chk("t5_busy", {31'b0, bus.busy}, 32'd1);
            if (i == 1) begin
                bus.start = 1'b1;
                bus.op = 3'd5;
                bus.a = 32'hCAFE_F00D;
            end
            tick();
            bus.start = 1'b0;
        end
        {m_hi, m_lo} = res;
        chk("t5_busy_done", {31'b0, bus.busy}, 32'd0);
        chk("t5_hi", bus.hi, m_hi);
        chk("t5_lo", bus.lo, m_lo);
        // Reset in the third busy cycle discards the pending result
        bus.start = 1'b1;
        bus.op = 3'd1;
        bus.a = $urandom;
        bus.b = $urandom;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("t5r_busy", {31'b0, bus.busy}, 32'd0);
        chk("t5r_hi", bus.hi, 32'd0);
        chk("t5r_lo", bus.lo, 32'd0);
        for (int i = 0; i < DIV_N; i++) tick();
        chk("t5r_busy_late", {31'b0, bus.busy}, 32'd0);
        chk("t5r_hi_late", bus.hi, 32'd0);
        chk("t5r_lo_late", bus.lo, 32'd0);
        // Reset coinciding with an accept wins
        bus.start = 1'b1;
        bus.op = 3'd4;
        bus.a = 32'h7777_7777;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_start_hi", bus.hi, 32'd0);
        run_op(3'd3, 32'd100, 32'd7);
        run_op(3'd0, 32'h7FFF_FFFF, 32'h8000_0000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
